// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// Avalon-MM slave that owns the 8-bit board LED output. The LEDs show either
// a CPU-written direct value (DATA) or an autonomous four-step pattern
// sequence (PAT0..PAT3), advanced every DIV+1 clocks. The sequence can loop
// or run once, and can be started, restarted or aborted with CTRL writes.
//
// Optional build macro: LED_SEQ_PWM_EN
//   defined   - an 8-bit free-running counter (pwm_cnt) gates out_port with
//               a programmable duty (CTRL[23:16], 0xFF = always on).
//   undefined - no PWM hardware, DUTY reads 0 and out_port is unmasked.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (0 DATA, 1 CTRL, 2 DIV, 3 STATUS, 4-7 PAT0-3)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational from address (zero wait states)
//   out_port    registered LED drive
// ---------------------------------------------------------------------------
module led_sequencer #(
    parameter int DIV_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_DIV    = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic       wr_en;
    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_div;
    logic       wr_status;
    logic [3:0] wr_pat;

    assign wr_en     = chipselect && !write_n;
    assign wr_data   = wr_en && (address == ADDR_DATA);
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
    assign wr_div    = wr_en && (address == ADDR_DIV);
    assign wr_status = wr_en && (address == ADDR_STATUS);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pat_dec
            assign wr_pat[gi] = wr_en && (address == 3'(4 + gi));
        end
    endgenerate

    // Bits above the widest register field carry no meaning on writes.
    logic [31:0] unused_writedata;
    assign unused_writedata = writedata;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [7:0]       data_reg;
    logic             run_reg;
    logic             oneshot_reg;
    logic [1:0]       last_reg;
    logic [DIV_W-1:0] div_reg;
    logic             done_reg;
    logic [7:0]       pat_reg [4];
    logic             start_req_reg;

    state_t           state_reg,  state_next;
    logic [1:0]       index_reg,  index_next;
    logic [DIV_W-1:0] count_reg,  count_next;
    logic [7:0]       level_reg,  level_next;
    logic             seq_done;
    logic [1:0]       index_inc;
    logic [7:0]       duty_rd;

    assign index_inc = index_reg + 2'd1;

    // ------------------------------------------------------------------
    // Sequencer next-state logic. level_next is the unmasked LED value
    // that out_port will carry after the coming edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        count_next = count_reg;
        level_next = level_reg;
        seq_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                level_next = data_reg;
                if (start_req_reg) begin
                    state_next = STEP;
                    index_next = 2'd0;
                    count_next = div_reg;
                    level_next = pat_reg[0];
                end
            end
            STEP: begin
                if (start_req_reg) begin
                    // RUN rewritten to 1 while running: restart from step 0
                    index_next = 2'd0;
                    count_next = div_reg;
                    level_next = pat_reg[0];
                end else if (!run_reg) begin
                    // Abort: index is left where it was for STATUS readback
                    state_next = IDLE;
                    level_next = data_reg;
                end else if (count_reg != '0) begin
                    count_next = count_reg - DIV_W'(1);
                end else if (index_reg != last_reg) begin
                    index_next = index_inc;
                    count_next = div_reg;
                    level_next = pat_reg[index_inc];
                end else if (!oneshot_reg) begin
                    index_next = 2'd0;
                    count_next = div_reg;
                    level_next = pat_reg[0];
                end else begin
                    state_next = IDLE;
                    level_next = data_reg;
                    seq_done   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            index_reg     <= 2'd0;
            count_reg     <= '0;
            level_reg     <= 8'd0;
            data_reg      <= 8'd0;
            run_reg       <= 1'b0;
            oneshot_reg   <= 1'b0;
            last_reg      <= 2'd0;
            div_reg       <= '0;
            done_reg      <= 1'b0;
            start_req_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            count_reg <= count_next;
            level_reg <= level_next;

            // Any RUN=1 write (re)starts the sequence on the following edge
            start_req_reg <= wr_ctrl && writedata[0];

            if (wr_data) begin
                data_reg <= writedata[7:0];
            end

            // Hardware clear first so a simultaneous CPU CTRL write wins
            if (seq_done) begin
                run_reg <= 1'b0;
            end
            if (wr_ctrl) begin
                run_reg     <= writedata[0];
                oneshot_reg <= writedata[1];
                last_reg    <= writedata[9:8];
            end

            if (wr_div) begin
                div_reg <= writedata[DIV_W-1:0];
            end

            // Completion has priority over a write-1-to-clear
            if (seq_done) begin
                done_reg <= 1'b1;
            end else if (wr_status && writedata[1]) begin
                done_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                pat_reg[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_pat[i]) begin
                    pat_reg[i] <= writedata[7:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef LED_SEQ_PWM_EN
    logic [7:0] duty_reg;
    logic [7:0] pwm_cnt;
    logic       pwm_on;
    logic [7:0] out_port_reg;

    // 0xFF is treated as fully on so the LEDs never blink at max duty
    assign pwm_on = (pwm_cnt < duty_reg) || (duty_reg == 8'hFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_reg     <= 8'hFF;
            pwm_cnt      <= 8'd0;
            out_port_reg <= 8'd0;
        end else begin
            if (wr_ctrl) begin
                duty_reg <= writedata[23:16];
            end
            pwm_cnt      <= pwm_cnt + 8'd1;
            out_port_reg <= pwm_on ? level_next : 8'd0;
        end
    end

    assign out_port = out_port_reg;
    assign duty_rd  = duty_reg;
`else
    // Without PWM the held LED value register drives the pins directly
    assign out_port = level_reg;
    assign duty_rd  = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Read mux (combinational, zero wait states)
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0: readdata = {24'd0, data_reg};
            3'd1: readdata = {8'd0, duty_rd, 6'd0, last_reg, 6'd0, oneshot_reg, run_reg};
            3'd2: readdata = 32'(div_reg);
            3'd3: readdata = {22'd0, index_reg, 6'd0, done_reg, (state_reg == STEP)};
            3'd4: readdata = {24'd0, pat_reg[0]};
            3'd5: readdata = {24'd0, pat_reg[1]};
            3'd6: readdata = {24'd0, pat_reg[2]};
            3'd7: readdata = {24'd0, pat_reg[3]};
            default: readdata = 32'd0;
        endcase
    end

endmodule
